// File: rtl/seg_scan_pkg.sv
// Shared defaults and helpers for the multiplexed seven-segment scan driver.
package seg_scan_pkg;

    localparam int unsigned DEF_NUM_DIGITS     = 8;
    localparam int unsigned DEF_SCAN_DIV       = 100000;
    localparam int unsigned DEF_BRIGHT_W       = 4;
    localparam int unsigned DEF_DEAD_CYC       = 2;
    localparam int unsigned DEF_SEG_ACTIVE_LOW = 1;
    localparam int unsigned DEF_DIG_ACTIVE_LOW = 1;

    // Prescaler cycles per brightness code step.
    function automatic int unsigned calc_step(input int unsigned scan_div,
                                              input int unsigned bright_w);
        return scan_div / (32'd1 << bright_w);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Segment data, enables and brightness in; scanned digit/segment drive out.
interface seg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BRIGHT_W   = 4
) ();
    logic [NUM_DIGITS*8-1:0] i_segs;
    logic                    i_load;
    logic [NUM_DIGITS-1:0]   i_digit_en;
    logic [BRIGHT_W-1:0]     i_brightness;
    logic [7:0]              o_segments;
    logic [NUM_DIGITS-1:0]   o_digits;
    logic                    o_frame_start;

    modport master (
        output i_segs, i_load, i_digit_en, i_brightness,
        input  o_segments, o_digits, o_frame_start
    );

    modport slave (
        input  i_segs, i_load, i_digit_en, i_brightness,
        output o_segments, o_digits, o_frame_start
    );
endinterface

// File: rtl/seg_scan_timer.sv
// Slot prescaler and digit index; flags the last cycle of each slot and frame.
module seg_scan_timer #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned CNT_W      = 17,
    parameter int unsigned IDX_W      = 3
) (
    input  logic             i_sclk,
    input  logic             i_reset,
    output logic [CNT_W-1:0] cnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             slot_end_o,
    output logic             frame_end_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_digit;

    assign slot_end_o  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign last_digit  = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frame_end_o = slot_end_o && last_digit;
    assign cnt_o       = cnt_q;
    assign idx_o       = idx_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end_o) begin
            cnt_d = '0;
            idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with tear-free frame updates, dead-time
// blanking and per-slot PWM brightness.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = DEF_NUM_DIGITS,
    parameter int unsigned SCAN_DIV       = DEF_SCAN_DIV,
    parameter int unsigned BRIGHT_W       = DEF_BRIGHT_W,
    parameter int unsigned DEAD_CYC       = DEF_DEAD_CYC,
    parameter int unsigned SEG_ACTIVE_LOW = DEF_SEG_ACTIVE_LOW,
    parameter int unsigned DIG_ACTIVE_LOW = DEF_DIG_ACTIVE_LOW
) (
    input  logic          i_sclk,
    input  logic          i_reset,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned STEP   = calc_step(SCAN_DIV, BRIGHT_W);
    localparam int unsigned PROD_W = BRIGHT_W + 32;
    localparam logic [7:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("seg_scan_driver: NUM_DIGITS must be 1..16");
    end
    if (SCAN_DIV < (32'd1 << BRIGHT_W)) begin : g_bad_div
        $error("seg_scan_driver: SCAN_DIV must be >= 2**BRIGHT_W");
    end
    if (DEAD_CYC >= SCAN_DIV) begin : g_bad_dead
        $error("seg_scan_driver: DEAD_CYC must be < SCAN_DIV");
    end

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    slot_end, frame_end;
    logic [NUM_DIGITS*8-1:0] pending_q, pending_d, display_q, display_d;
    logic [BRIGHT_W-1:0]     bright_q, bright_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d, dig_sel;
    logic                    fs_q, fs_d;
    logic [7:0]              byte_sel;
    logic                    en_sel, pwm_on, lit;
    logic [PROD_W-1:0]       duty_lim;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) u_timer (
        .i_sclk      (i_sclk),
        .i_reset     (i_reset),
        .cnt_o       (cnt),
        .idx_o       (idx),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end)
    );

    // A load landing on the frame boundary goes straight through to display.
    assign pending_d = bus.i_load ? bus.i_segs : pending_q;
    assign display_d = frame_end ? pending_d : display_q;
    assign bright_d  = slot_end ? bus.i_brightness : bright_q;

    always_comb begin
        dig_sel  = '0;
        byte_sel = '0;
        en_sel   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dig_sel[k] = (idx == IDX_W'(k));
            byte_sel   = byte_sel | ({8{dig_sel[k]}} & display_q[8*k +: 8]);
            en_sel     = en_sel | (dig_sel[k] & bus.i_digit_en[k]);
        end
    end

    assign duty_lim = PROD_W'(bright_q) * PROD_W'(STEP);
    assign pwm_on   = (&bright_q) || (PROD_W'(cnt) < duty_lim);
    assign lit      = en_sel && (cnt >= CNT_W'(DEAD_CYC)) && pwm_on;

    assign seg_d = (lit ? byte_sel : 8'h00) ^ SEG_INV;
    assign dig_d = (lit ? dig_sel : '0) ^ DIG_INV;
    assign fs_d  = (cnt == '0) && (idx == '0);

    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            pending_q <= '0;
            display_q <= '0;
            bright_q  <= '0;
            seg_q     <= SEG_INV;
            dig_q     <= DIG_INV;
            fs_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            display_q <= display_d;
            bright_q  <= bright_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            fs_q      <= fs_d;
        end
    end

    assign bus.o_segments    = seg_q;
    assign bus.o_digits      = dig_q;
    assign bus.o_frame_start = fs_q;

endmodule
